// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the data-memory access stage.
// Holds the FSM state encoding, funct3 codes and the alignment helper.
package mem_stage_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] SD = 3'b011;

  // The access size lives in funct3[1:0] for both loads and stores.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/grant/response bus between the memory stage and the memory.
interface memory_stage_if #(parameter int XLEN = mem_stage_pkg::XLEN_DEFAULT);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            gnt;
  logic            rvalid;
  logic [63:0]     rdata;

  modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_align.sv
// Extracts the addressed lane from a read doubleword and sign/zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    result = shifted;
    case (funct3)
      LB:      result = {{56{shifted[7]}},  shifted[7:0]};
      LH:      result = {{48{shifted[15]}}, shifted[15:0]};
      LW:      result = {{32{shifted[31]}}, shifted[31:0]};
      LBU:     result = {56'd0, shifted[7:0]};
      LHU:     result = {48'd0, shifted[15:0]};
      LWU:     result = {32'd0, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Data-memory access stage: request/grant/response FSM, store lane formatting,
// alignment/funct3 fault detection and load result hand-off to write-back.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rd2,
  output logic            out_valid,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_fault,
  output logic            busy,
  memory_stage_if.master  dmem
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]      state_reg;
  logic            read_reg;
  logic [2:0]      f3_reg;
  logic [XLEN-1:0] addr_reg;
  logic            out_valid_reg;
  logic            mem_fault_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic            dmem_req_reg;
  logic            dmem_we_reg;
  logic [XLEN-1:0] dmem_addr_reg;
  logic [63:0]     dmem_wdata_reg;
  logic [7:0]      dmem_wstrb_reg;

  logic [2:0]  off_next;
  logic        is_mem;
  logic        illegal_f3;
  logic        fault_next;
  logic        go_mem;
  logic [7:0]  strb_base;
  logic [7:0]  wstrb_next;
  logic [63:0] wdata_next;
  logic [63:0] load_result;

  // Decode of the incoming instruction; only consumed in IDLE on acceptance.
  always_comb begin
    off_next   = alu_result[2:0];
    is_mem     = mem_read | mem_write;
    illegal_f3 = mem_read ? (funct3 == 3'b111) : (mem_write & funct3[2]);
    fault_next = is_mem & (illegal_f3 | misaligned(funct3[1:0], off_next));
    go_mem     = is_mem & ~fault_next;
    case (funct3)
      SB:      strb_base = 8'h01;
      SH:      strb_base = 8'h03;
      SW:      strb_base = 8'h0F;
      SD:      strb_base = 8'hFF;
      default: strb_base = 8'h00;
    endcase
    wstrb_next = mem_write ? (strb_base << off_next) : 8'h00;
    wdata_next = mem_write ? (64'(rd2) << {off_next, 3'b000}) : 64'd0;
  end

  load_align u_load_align (
    .rdata  (dmem.rdata),
    .off    (addr_reg[2:0]),
    .funct3 (f3_reg),
    .result (load_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      read_reg       <= 1'b0;
      f3_reg         <= 3'b000;
      addr_reg       <= '0;
      out_valid_reg  <= 1'b0;
      mem_fault_reg  <= 1'b0;
      wb_data_reg    <= '0;
      dmem_req_reg   <= 1'b0;
      dmem_we_reg    <= 1'b0;
      dmem_addr_reg  <= '0;
      dmem_wdata_reg <= 64'd0;
      dmem_wstrb_reg <= 8'h00;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            read_reg <= mem_read;
            f3_reg   <= funct3;
            addr_reg <= alu_result;
            if (go_mem) begin
              state_reg      <= S_REQ;
              dmem_req_reg   <= 1'b1;
              dmem_we_reg    <= mem_write;
              dmem_addr_reg  <= {alu_result[XLEN-1:3], 3'b000};
              dmem_wdata_reg <= wdata_next;
              dmem_wstrb_reg <= wstrb_next;
            end else begin
              // Non-memory ops and faulting accesses complete without touching memory.
              state_reg     <= S_DONE;
              out_valid_reg <= 1'b1;
              mem_fault_reg <= fault_next;
              wb_data_reg   <= alu_result;
            end
          end
        end
        S_REQ: begin
          if (dmem.gnt) begin
            dmem_req_reg <= 1'b0;
            if (read_reg) begin
              state_reg <= S_WAIT;
            end else begin
              state_reg     <= S_DONE;
              out_valid_reg <= 1'b1;
              mem_fault_reg <= 1'b0;
              wb_data_reg   <= addr_reg;
            end
          end
        end
        S_WAIT: begin
          if (dmem.rvalid) begin
            state_reg     <= S_DONE;
            out_valid_reg <= 1'b1;
            mem_fault_reg <= 1'b0;
            wb_data_reg   <= XLEN'(load_result);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign out_valid  = out_valid_reg;
  assign mem_fault  = mem_fault_reg;
  assign wb_data    = wb_data_reg;
  assign dmem.req   = dmem_req_reg;
  assign dmem.we    = dmem_we_reg;
  assign dmem.addr  = dmem_addr_reg;
  assign dmem.wdata = dmem_wdata_reg;
  assign dmem.wstrb = dmem_wstrb_reg;

endmodule

// File: doc/memory_stage.md
# memory_stage

Data-memory access stage of the RV64 core. It sits directly downstream of `execute_stage` and consumes its ALU result as an effective address or pass-through value, along with the store operand and `funct3`. It runs a request/grant/response handshake with the data memory and formats store data, byte strobes and load results. It hands one write-back value per accepted instruction to the write-back stage and stalls upstream while an access is in flight.

## Interface
- `XLEN`, 64: datapath and address width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: execute result valid this cycle.
- `in_ready` out 1: stage can accept; high only in IDLE.
- `mem_read` in 1: load instruction.
- `mem_write` in 1: store instruction. Never asserted together with `mem_read`.
- `funct3` in 3: access size/sign.
- `alu_result` in XLEN: effective address, or pass-through result.
- `rd2` in XLEN: store data.
- `out_valid` out 1: one-cycle pulse; `wb_data`/`mem_fault` valid.
- `wb_data` out XLEN: load result, or captured `alu_result` for non-memory ops and stores.
- `mem_fault` out 1: misaligned access or illegal `funct3`.
- `busy` out 1: state != IDLE.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out XLEN: doubleword-aligned address, low 3 bits forced to 0.
- `dmem_wdata` out 64: lane-shifted store data.
- `dmem_wstrb` out 8: byte enables; 0 for reads.
- `dmem_gnt` in 1: memory accepted request.
- `dmem_rvalid` in 1: read data valid; arrives no earlier than the cycle after `dmem_gnt`.
- `dmem_rdata` in 64: read doubleword.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - On `in_valid`, register `mem_read`, `mem_write`, `funct3`, `alu_result`, `rd2`.
  - Next state is always DONE, except for a legal, aligned load/store, which goes to REQ.
- **REQ**
  - Hold `dmem_req`=1 with stable `dmem_we`/`dmem_addr`/`dmem_wdata`/`dmem_wstrb` until `dmem_gnt`.
  - On `gnt`: a store goes to DONE; a load goes to WAIT.
- **WAIT**: on `dmem_rvalid`, capture the extracted load data and go to DONE.
- **DONE**: `out_valid`=1 for exactly one cycle, then return to IDLE.
- Byte offset `off` = `addr[2:0]`.
- Alignment faults:
  - Half faults if `addr[0]`.
  - Word faults if `addr[1:0]` != 0.
  - Double faults if `off` != 0.
  - Byte accesses never fault.
- Illegal `funct3`: load `111`; store `1xx`.
- On any fault: no memory request, `mem_fault`=1, `wb_data`=captured address.
- Store strobes, all shifted left by `off`:
  - `000` → `0x01`
  - `001` → `0x03`
  - `010` → `0x0F`
  - `011` → `0xFF`
- Store data: `dmem_wdata` = `rd2 << (8*off)`.
- Load extraction:
  - Raw value is `dmem_rdata >> (8*off)`, truncated to 8/16/32/64 bits.
  - Sign-extend for `000`/`001`/`010` (LB/LH/LW).
  - Zero-extend for `100`/`101`/`110` (LBU/LHU/LWU).
  - `011` (LD) uses the full 64 bits.
- Store and non-memory ops: `wb_data` = captured `alu_result`.

## Timing
- Acceptance cycle is T0, i.e. IDLE with `in_valid`.
- Non-memory op or fault: `out_valid` at T1.
- Store with `gnt` at T1: `out_valid` at T2. Each extra cycle without `gnt` adds one cycle.
- Load with `gnt` at T1 and `rvalid` at T2: `out_valid` at T3.
- `in_ready`=0 from T1 through the DONE cycle inclusive. The next instruction can be accepted in the cycle after DONE.
- `dmem_rvalid` in any state other than WAIT is ignored.
- Reset values, registered:
  - State IDLE.
  - `out_valid`, `mem_fault`, `busy`, `dmem_req`, `dmem_we` = 0.
  - `wb_data`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb` = 0.
  - `in_ready`=1 the cycle after reset deasserts.
- Reset mid-access (REQ/WAIT) abandons the access:
  - `dmem_req` is low in the cycle after the reset edge.
  - No `out_valid` is produced.
  - A late `rvalid` is discarded.

## Structure
- Package `mem_stage_pkg`:
  - State enum.
  - Load `funct3` constants: `LB`, `LH`, `LW`, `LD`, `LBU`, `LHU`, `LWU`.
  - Store `funct3` constants: `SB`, `SH`, `SW`, `SD`.
  - `XLEN` default.
- One combinational sub-module, `load_align`, maps (`rdata`, `off`, `funct3`) to a 64-bit extended result. The FSM, strobe/shift logic and fault check stay in `memory_stage`.

## Test plan
- **Non-memory op:** `in_valid`, `alu_result`=`0x1234` → `out_valid` at T1, `wb_data`=`0x1234`, `dmem_req` never asserted.
- **SB, immediate grant:** SB at addr `0x1003`, `rd2`=`0xAB`, `gnt` at T1 → `dmem_addr`=`0x1000`, `wstrb`=`0x08`, `wdata[31:24]`=`0xAB`, `out_valid` at T2.
- **LH with stalled grant:** LH at addr `0x2006`, `gnt` withheld 3 cycles, `rdata`=`0x8001_0000_0000_0000` → request held stable; `wb_data`=`0xFFFF_FFFF_FFFF_8001`.
- **LWU/LW extension:** LWU at `0x2004`, `rdata[63:32]`=`0xF000_0000` → `wb_data`=`0x0000_0000_F000_0000`. Same access as LW → `0xFFFF_FFFF_F000_0000`.
- **Faults:** LD at `0x3004` → `mem_fault`=1 at T1, no request. Store with `funct3`=`100` → `mem_fault`=1.
- **Reset mid-load:** `rst` in WAIT, then `rvalid` → no `out_valid`; state IDLE; `in_ready`=1 afterwards.
